kf_snn_tile_sched: RTL and testbench

Per-tile front-end scheduler for the spiking-neuron core. Each cycle it round-robin arbitrates up to N_SRC spike sources (NoC ports, local loopback, host injection) onto the core's single spike-input port. It also owns the core's configuration port: it quiesces spike traffic, waits for the core to go idle, then lets a host write a burst of synapse, index or membrane words. It sits between the tile's NoC router and the core, and is the core's only driver of spike_in_* and cfg_*.

---
 rtl/kf_snn_tile_sched.sv | 180 ++++++++++++++++++
 tb/tb_kf_snn_tile_sched.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kf_snn_tile_sched.sv
// Tile front-end: round-robin spike arbiter onto the core input, plus a quiesce-then-write config port.
// Latency: 1 cycle from source grant to core spike; 1 cycle from host beat to cfg_we pulse.
// Backpressure: held spike frozen until core_spike_ready; src/hcfg ready are combinational from state.
module kf_snn_tile_sched #(
  parameter int N_SRC = 4,
  parameter int NID_W = 16,   // presynaptic neuron id width of the core
  parameter int SID_W = 16    // config word address width of the core
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [N_SRC-1:0]       src_valid_i,
  output logic [N_SRC-1:0]       src_ready_o,
  input  logic [N_SRC*NID_W-1:0] src_pre_id_i,
  input  logic [N_SRC*8-1:0]     src_payload_i,
  output logic                   core_spike_valid_o,
  input  logic                   core_spike_ready_i,
  output logic [NID_W-1:0]       core_pre_id_o,
  output logic [7:0]             core_payload_o,
  input  logic                   core_busy_i,
  input  logic                   hcfg_valid_i,
  output logic                   hcfg_ready_o,
  input  logic [1:0]             hcfg_sel_i,
  input  logic [SID_W-1:0]       hcfg_addr_i,
  input  logic [31:0]            hcfg_wdata_i,
  input  logic                   hcfg_last_i,
  output logic                   cfg_we_o,
  output logic [1:0]             cfg_sel_o,
  output logic [SID_W-1:0]       cfg_addr_o,
  output logic [31:0]            cfg_wdata_o,
  output logic [31:0]            stat_spike_cnt_o,
  output logic [15:0]            stat_cfg_cnt_o,
  output logic                   cfg_mode_o
);

  localparam int PTR_W = $clog2(N_SRC);
  localparam int SUM_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_CFG     = 2'd2,
    ST_CFG_END = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] rr_q, rr_d;
  logic             spk_vld_q, spk_vld_d;
  logic [NID_W-1:0] spk_id_q, spk_id_d;
  logic [7:0]       spk_pay_q, spk_pay_d;
  logic             cfg_we_q, cfg_we_d;
  logic [1:0]       cfg_sel_q, cfg_sel_d;
  logic [SID_W-1:0] cfg_addr_q, cfg_addr_d;
  logic [31:0]      cfg_wdata_q, cfg_wdata_d;
  logic [31:0]      spk_cnt_q, spk_cnt_d;
  logic [15:0]      cfg_cnt_q, cfg_cnt_d;

  logic             win_found;
  logic [PTR_W-1:0] win_idx;
  logic [SUM_W-1:0] cand_sum;
  logic             load_en;

  // Round-robin search: first valid source starting one past the last winner, wrapping back to it.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_sum  = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      cand_sum = SUM_W'(rr_q) + SUM_W'(k);
      if (cand_sum >= SUM_W'(N_SRC)) cand_sum = cand_sum - SUM_W'(N_SRC);
      if (!win_found && src_valid_i[cand_sum[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand_sum[PTR_W-1:0];
      end
    end
  end

  // Next-state, grant and config-beat logic; readies are forced low while reset is asserted.
  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    spk_vld_d    = spk_vld_q;
    spk_id_d     = spk_id_q;
    spk_pay_d    = spk_pay_q;
    cfg_we_d     = 1'b0;
    cfg_sel_d    = cfg_sel_q;
    cfg_addr_d   = cfg_addr_q;
    cfg_wdata_d  = cfg_wdata_q;
    spk_cnt_d    = spk_cnt_q;
    cfg_cnt_d    = cfg_cnt_q;
    src_ready_o  = '0;
    hcfg_ready_o = 1'b0;
    load_en      = 1'b0;

    // An accepted spike leaves the output register unless a new one is loaded this cycle.
    if (spk_vld_q && core_spike_ready_i) begin
      spk_vld_d = 1'b0;
      spk_cnt_d = spk_cnt_q + 32'd1;
    end

    case (state_q)
      ST_RUN: begin
        // A pending host request blocks new grants so the drain can start immediately.
        load_en = (!spk_vld_q || core_spike_ready_i) && !hcfg_valid_i;
        if (load_en && win_found) begin
          src_ready_o[win_idx] = 1'b1;
          spk_vld_d = 1'b1;
          spk_id_d  = src_pre_id_i[win_idx*NID_W +: NID_W];
          spk_pay_d = src_payload_i[win_idx*8 +: 8];
          rr_d      = win_idx;
        end
        if (hcfg_valid_i) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!spk_vld_q && !core_busy_i) state_d = ST_CFG;
      end
      ST_CFG: begin
        hcfg_ready_o = 1'b1;
        if (hcfg_valid_i) begin
          cfg_we_d    = 1'b1;
          cfg_sel_d   = hcfg_sel_i;
          cfg_addr_d  = hcfg_addr_i;
          cfg_wdata_d = hcfg_wdata_i;
          cfg_cnt_d   = cfg_cnt_q + 16'd1;
          if (hcfg_last_i) state_d = ST_CFG_END;
        end
      end
      ST_CFG_END: begin
        // cfg_we_q still carries the final pulse here; spikes resume next cycle.
        state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase

    if (!rst_n_i) begin
      src_ready_o  = '0;
      hcfg_ready_o = 1'b0;
    end
  end

  // State and datapath registers with synchronous active-low reset; reset discards any held spike.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_RUN;
      rr_q        <= PTR_W'(N_SRC - 1);
      spk_vld_q   <= 1'b0;
      spk_id_q    <= '0;
      spk_pay_q   <= '0;
      cfg_we_q    <= 1'b0;
      cfg_sel_q   <= '0;
      cfg_addr_q  <= '0;
      cfg_wdata_q <= '0;
      spk_cnt_q   <= '0;
      cfg_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      spk_vld_q   <= spk_vld_d;
      spk_id_q    <= spk_id_d;
      spk_pay_q   <= spk_pay_d;
      cfg_we_q    <= cfg_we_d;
      cfg_sel_q   <= cfg_sel_d;
      cfg_addr_q  <= cfg_addr_d;
      cfg_wdata_q <= cfg_wdata_d;
      spk_cnt_q   <= spk_cnt_d;
      cfg_cnt_q   <= cfg_cnt_d;
    end
  end

  assign core_spike_valid_o = spk_vld_q;
  assign core_pre_id_o      = spk_id_q;
  assign core_payload_o     = spk_pay_q;
  assign cfg_we_o           = cfg_we_q;
  assign cfg_sel_o          = cfg_sel_q;
  assign cfg_addr_o         = cfg_addr_q;
  assign cfg_wdata_o        = cfg_wdata_q;
  assign stat_spike_cnt_o   = spk_cnt_q;
  assign stat_cfg_cnt_o     = cfg_cnt_q;
  assign cfg_mode_o         = (state_q != ST_RUN);

endmodule

// File: tb/tb_kf_snn_tile_sched.sv
// Bench for kf_snn_tile_sched: vector table for arbitration, hand sequences for drain/config/reset,
// randomized spike traffic against a round-robin reference model, and config counter wrap.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1-2 units after it.
module tb_kf_snn_tile_sched;

  localparam int N  = 4;
  localparam int NW = 16;
  localparam int SW = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0]    src_valid, src_ready;
  logic [N*NW-1:0] src_pre_id;
  logic [N*8-1:0]  src_payload;
  logic            core_spike_valid, core_spike_ready, core_busy;
  logic [NW-1:0]   core_pre_id;
  logic [7:0]      core_payload;
  logic            hcfg_valid, hcfg_ready, hcfg_last;
  logic [1:0]      hcfg_sel;
  logic [SW-1:0]   hcfg_addr;
  logic [31:0]     hcfg_wdata;
  logic            cfg_we, cfg_mode;
  logic [1:0]      cfg_sel;
  logic [SW-1:0]   cfg_addr;
  logic [31:0]     cfg_wdata, stat_spike_cnt;
  logic [15:0]     stat_cfg_cnt;

  logic [NW-1:0]   src_id [N];
  logic [7:0]      src_pay [N];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  sv;
    logic        rdy;
    logic [3:0]  exp_rdy;
    logic        exp_vld;
    logic [15:0] exp_id;
    logic [31:0] exp_cnt;
  } vec_t;
  vec_t tbl [17];

  // Reference model state for the randomized phase.
  bit          m_pend, m_found, m_load;
  int          m_rr, m_w;
  logic [31:0] m_cnt;
  logic [15:0] m_id;
  logic [7:0]  m_pay;
  logic [3:0]  m_ready;

  int grant_cyc, we_cyc;
  bit hs;

  // 100 MHz-style free-running clock.
  always #5 clk = ~clk;

  // Pack the per-source id/payload arrays onto the flat buses.
  always_comb begin
    src_pre_id  = '0;
    src_payload = '0;
    for (int i = 0; i < N; i++) begin
      src_pre_id[i*NW +: NW] = src_id[i];
      src_payload[i*8 +: 8]  = src_pay[i];
    end
  end

  kf_snn_tile_sched #(.N_SRC(N), .NID_W(NW), .SID_W(SW)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .src_valid_i(src_valid), .src_ready_o(src_ready),
    .src_pre_id_i(src_pre_id), .src_payload_i(src_payload),
    .core_spike_valid_o(core_spike_valid), .core_spike_ready_i(core_spike_ready),
    .core_pre_id_o(core_pre_id), .core_payload_o(core_payload), .core_busy_i(core_busy),
    .hcfg_valid_i(hcfg_valid), .hcfg_ready_o(hcfg_ready), .hcfg_sel_i(hcfg_sel),
    .hcfg_addr_i(hcfg_addr), .hcfg_wdata_i(hcfg_wdata), .hcfg_last_i(hcfg_last),
    .cfg_we_o(cfg_we), .cfg_sel_o(cfg_sel), .cfg_addr_o(cfg_addr), .cfg_wdata_o(cfg_wdata),
    .stat_spike_cnt_o(stat_spike_cnt), .stat_cfg_cnt_o(stat_cfg_cnt), .cfg_mode_o(cfg_mode)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ids();
    for (int i = 0; i < N; i++) begin
      src_id[i]  = 16'(10 + i);
      src_pay[i] = 8'(8'hA0 + i);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    src_valid = '1;
    hcfg_valid = 1'b0;
    core_spike_ready = 1'b0;
    core_busy = 1'b0;
    tick();
    #1;
    chk("rst_src_ready", src_ready, 4'b0000);
    chk("rst_hcfg_ready", hcfg_ready, 1'b0);
    tick();
    rst_n = 1'b1;
    src_valid = '0;
  endtask

  // One host beat: wait (bounded) for hcfg_ready, handshake, then check the registered write.
  task automatic send_beat(input logic [1:0] sel, input logic [15:0] addr, input logic [31:0] data,
                           input logic last, input logic [15:0] exp_cnt);
    int n;
    n = 0;
    hcfg_valid = 1'b1;
    hcfg_sel = sel;
    hcfg_addr = addr;
    hcfg_wdata = data;
    hcfg_last = last;
    #1;
    while (!hcfg_ready && n < 50) begin
      tick();
      #1;
      n++;
    end
    chk("beat_accept_wait", hcfg_ready, 1'b1);
    tick();
    if (last) hcfg_valid = 1'b0;
    chk("beat_cfg_we", cfg_we, 1'b1);
    chk("beat_cfg_sel", cfg_sel, sel);
    chk("beat_cfg_addr", cfg_addr, addr);
    chk("beat_cfg_wdata", cfg_wdata, data);
    chk("beat_cfg_cnt", stat_cfg_cnt, exp_cnt);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // Main test sequence.
  initial begin
    //            sv       rdy   exp_rdy  vld   id      cnt
    tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 16'd10, 32'd0};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 16'd11, 32'd1};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 16'd12, 32'd2};
    tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 16'd13, 32'd3};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 16'd10, 32'd4};
    tbl[5]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 16'd0,  32'd5};
    tbl[6]  = '{4'b0010, 1'b0, 4'b0010, 1'b1, 16'd11, 32'd5};
    tbl[7]  = '{4'b0101, 1'b0, 4'b0000, 1'b1, 16'd11, 32'd5};
    tbl[8]  = '{4'b0101, 1'b1, 4'b0100, 1'b1, 16'd12, 32'd6};
    tbl[9]  = '{4'b1001, 1'b1, 4'b1000, 1'b1, 16'd13, 32'd7};
    tbl[10] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 16'd10, 32'd8};
    tbl[11] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 16'd10, 32'd8};
    tbl[12] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 16'd0,  32'd9};
    tbl[13] = '{4'b1010, 1'b1, 4'b0010, 1'b1, 16'd11, 32'd9};
    tbl[14] = '{4'b1010, 1'b1, 4'b1000, 1'b1, 16'd13, 32'd10};
    tbl[15] = '{4'b1010, 1'b1, 4'b0010, 1'b1, 16'd11, 32'd11};
    tbl[16] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 16'd0,  32'd12};

    set_ids();
    src_valid = '0;
    core_spike_ready = 1'b0;
    core_busy = 1'b0;
    hcfg_valid = 1'b0;
    hcfg_sel = '0;
    hcfg_addr = '0;
    hcfg_wdata = '0;
    hcfg_last = 1'b0;
    rst_n = 1'b0;

    // Reset values.
    do_reset();
    chk("reset_spike_valid", core_spike_valid, 1'b0);
    chk("reset_pre_id", core_pre_id, 16'd0);
    chk("reset_payload", core_payload, 8'd0);
    chk("reset_cfg_we", cfg_we, 1'b0);
    chk("reset_cfg_sel", cfg_sel, 2'd0);
    chk("reset_cfg_addr", cfg_addr, 16'd0);
    chk("reset_cfg_wdata", cfg_wdata, 32'd0);
    chk("reset_spike_cnt", stat_spike_cnt, 32'd0);
    chk("reset_cfg_cnt", stat_cfg_cnt, 16'd0);
    chk("reset_cfg_mode", cfg_mode, 1'b0);

    // Arbitration vector table.
    for (int r = 0; r < 17; r++) begin
      src_valid = tbl[r].sv;
      core_spike_ready = tbl[r].rdy;
      #1;
      chk($sformatf("tbl%0d_src_ready", r), src_ready, tbl[r].exp_rdy);
      tick();
      chk($sformatf("tbl%0d_valid", r), core_spike_valid, tbl[r].exp_vld);
      if (tbl[r].exp_vld) begin
        chk($sformatf("tbl%0d_pre_id", r), core_pre_id, tbl[r].exp_id);
        chk($sformatf("tbl%0d_payload", r), core_payload, 8'(8'hA0 + 8'(tbl[r].exp_id - 16'd10)));
      end
      chk($sformatf("tbl%0d_spike_cnt", r), stat_spike_cnt, tbl[r].exp_cnt);
    end

    // Backpressure: source 1 held for 5 stalled cycles.
    do_reset();
    src_id[1] = 16'h21;
    src_valid = 4'b0010;
    core_spike_ready = 1'b0;
    #1;
    chk("bp_grant", src_ready, 4'b0010);
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid_held", core_spike_valid, 1'b1);
      chk("bp_id_stable", core_pre_id, 16'h21);
      #1;
      chk("bp_no_grant", src_ready, 4'b0000);
      tick();
    end
    chk("bp_cnt_stalled", stat_spike_cnt, 32'd0);
    core_spike_ready = 1'b1;
    src_valid = '0;
    tick();
    chk("bp_released_valid", core_spike_valid, 1'b0);
    chk("bp_released_cnt", stat_spike_cnt, 32'd1);
    core_spike_ready = 1'b0;
    set_ids();

    // Drain then config: pending spike, core busy after accept, 3-beat burst.
    do_reset();
    src_valid = 4'b0001;
    tick();
    src_valid = '0;
    chk("drain_spike_pending", core_spike_valid, 1'b1);
    core_busy = 1'b1;
    hcfg_valid = 1'b1;
    hcfg_sel = 2'd0;
    hcfg_addr = 16'd5;
    hcfg_wdata = 32'hC0DE_0000;
    hcfg_last = 1'b0;
    #1;
    chk("drain_run_hcfg_ready", hcfg_ready, 1'b0);
    tick();
    chk("drain_cfg_mode", cfg_mode, 1'b1);
    chk("drain_spike_held", core_spike_valid, 1'b1);
    core_spike_ready = 1'b1;
    #1;
    chk("drain_pending_hcfg_ready", hcfg_ready, 1'b0);
    tick();
    core_spike_ready = 1'b0;
    chk("drain_spike_accepted", core_spike_valid, 1'b0);
    chk("drain_spike_cnt", stat_spike_cnt, 32'd1);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("drain_busy_hcfg_ready", hcfg_ready, 1'b0);
      tick();
    end
    core_busy = 1'b0;
    #1;
    chk("drain_idle_hcfg_ready", hcfg_ready, 1'b0);
    tick();
    send_beat(2'd0, 16'd5, 32'hC0DE_0000, 1'b0, 16'd1);
    send_beat(2'd1, 16'd6, 32'hC0DE_0001, 1'b0, 16'd2);
    send_beat(2'd2, 16'd7, 32'hC0DE_0002, 1'b1, 16'd3);
    #1;
    chk("cfg_end_mode", cfg_mode, 1'b1);
    chk("cfg_end_hcfg_ready", hcfg_ready, 1'b0);
    tick();
    chk("post_burst_cfg_we", cfg_we, 1'b0);
    chk("post_burst_cfg_mode", cfg_mode, 1'b0);
    chk("post_burst_cfg_cnt", stat_cfg_cnt, 16'd3);

    // Simultaneous spike and host request; sel=3 forwarded unchanged.
    do_reset();
    src_valid = 4'b0001;
    hcfg_valid = 1'b1;
    hcfg_sel = 2'd3;
    hcfg_addr = 16'd9;
    hcfg_wdata = 32'h1234_5678;
    hcfg_last = 1'b1;
    grant_cyc = -1;
    we_cyc = -1;
    #1;
    chk("simul_no_grant", src_ready, 4'b0000);
    for (int c = 0; c < 20; c++) begin
      if (src_ready[0] && grant_cyc < 0) grant_cyc = c;
      hs = hcfg_valid && hcfg_ready;
      tick();
      if (hs) hcfg_valid = 1'b0;
      if (grant_cyc == c) src_valid = '0;
      if (cfg_we) we_cyc = c + 1;
      #1;
    end
    chk("simul_we_seen", we_cyc >= 0, 1'b1);
    chk("simul_grant_seen", grant_cyc >= 0, 1'b1);
    chk("simul_grant_after_we", grant_cyc > we_cyc, 1'b1);
    chk("simul_spike_delivered", core_spike_valid, 1'b1);
    chk("simul_spike_id", core_pre_id, 16'd10);
    chk("simul_sel3", cfg_sel, 2'd3);
    chk("simul_addr", cfg_addr, 16'd9);
    chk("simul_cfg_cnt", stat_cfg_cnt, 16'd1);

    // Reset mid-drain discards the held spike.
    do_reset();
    src_valid = 4'b0001;
    tick();
    src_valid = '0;
    hcfg_valid = 1'b1;
    hcfg_last = 1'b0;
    tick();
    chk("rdrain_cfg_mode", cfg_mode, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    hcfg_valid = 1'b0;
    chk("rdrain_spike_discarded", core_spike_valid, 1'b0);
    chk("rdrain_cfg_mode_low", cfg_mode, 1'b0);

    // Reset mid-burst after the first beat.
    send_beat(2'd1, 16'd1, 32'hAAAA_5555, 1'b0, 16'd1);
    rst_n = 1'b0;
    src_valid = 4'b1111;
    #1;
    chk("rburst_src_ready_forced", src_ready, 4'b0000);
    chk("rburst_hcfg_ready_forced", hcfg_ready, 1'b0);
    tick();
    rst_n = 1'b1;
    hcfg_valid = 1'b0;
    chk("rburst_cfg_we", cfg_we, 1'b0);
    chk("rburst_cfg_mode", cfg_mode, 1'b0);
    chk("rburst_spike_valid", core_spike_valid, 1'b0);
    chk("rburst_spike_cnt", stat_spike_cnt, 32'd0);
    chk("rburst_cfg_cnt", stat_cfg_cnt, 16'd0);
    #1;
    chk("rburst_first_grant", src_ready, 4'b0001);
    tick();
    chk("rburst_first_id", core_pre_id, 16'd10);
    src_valid = '0;

    // Randomized spike traffic against the round-robin model.
    do_reset();
    m_pend = 1'b0;
    m_rr = N - 1;
    m_cnt = '0;
    m_id = '0;
    m_pay = '0;
    for (int c = 0; c < 2000; c++) begin
      src_valid = 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) begin
        src_id[i]  = 16'($urandom);
        src_pay[i] = 8'($urandom);
      end
      core_spike_ready = ($urandom_range(0, 3) != 0);
      core_busy = 1'($urandom);
      #1;
      m_load = !m_pend || core_spike_ready;
      m_found = 1'b0;
      m_w = 0;
      for (int k = 1; k <= N; k++) begin
        if (!m_found && src_valid[(m_rr + k) % N]) begin
          m_found = 1'b1;
          m_w = (m_rr + k) % N;
        end
      end
      m_ready = '0;
      if (m_load && m_found) m_ready[m_w] = 1'b1;
      chk("rand_src_ready", src_ready, m_ready);
      chk("rand_valid", core_spike_valid, m_pend);
      if (m_pend) begin
        chk("rand_pre_id", core_pre_id, m_id);
        chk("rand_payload", core_payload, m_pay);
      end
      chk("rand_spike_cnt", stat_spike_cnt, m_cnt);
      if (m_pend && core_spike_ready) begin
        m_cnt = m_cnt + 32'd1;
        m_pend = 1'b0;
      end
      if (m_load && m_found) begin
        m_pend = 1'b1;
        m_id = src_id[m_w];
        m_pay = src_pay[m_w];
        m_rr = m_w;
      end
      tick();
    end
    src_valid = '0;
    core_spike_ready = 1'b0;
    set_ids();

    // Config counter wrap: 2^16+1 beats in one burst.
    do_reset();
    hcfg_valid = 1'b1;
    hcfg_sel = 2'd2;
    hcfg_wdata = 32'h0;
    hcfg_last = 1'b0;
    hcfg_addr = '0;
    #1;
    begin
      int n;
      n = 0;
      while (!hcfg_ready && n < 10) begin
        tick();
        #1;
        n++;
      end
    end
    chk("wrap_ready", hcfg_ready, 1'b1);
    for (int b = 0; b < 65537; b++) begin
      hcfg_last = (b == 65536);
      hcfg_addr = b[15:0];
      tick();
      if (b == 65535) chk("wrap_cnt_zero", stat_cfg_cnt, 16'd0);
      #1;
    end
    hcfg_valid = 1'b0;
    chk("wrap_cnt_one", stat_cfg_cnt, 16'd1);
    chk("wrap_last_we", cfg_we, 1'b1);
    chk("wrap_last_addr", cfg_addr, 16'd0);
    tick();
    chk("wrap_cfg_mode", cfg_mode, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
